// File: rtl/rtype_sequencer.sv
// rtype_sequencer: four-state controller that runs one RV32I R-type instruction through the register-file/ALU datapath
//   clk, rst (async, active-high)
//   instr_valid/instr/instr_ready           : instruction handshake
//   rs1_addr/rs2_addr/rd_addr/alu_ctrl      : registered datapath controls, updated in DECODE only
//   reg_write                               : one-cycle write strobe in EXEC, legal and rd != x0 only
//   alu_result/zero_flag                    : datapath result, captured in EXEC
//   resp_valid/resp_data/resp_zero/resp_err/resp_ready : response handshake
//   RTYPE_SEQ_PERF_EN defined               : adds retired_cnt/illegal_cnt handshake counters
module rtype_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic [3:0]      alu_ctrl,
    output logic            reg_write,
    input  logic [XLEN-1:0] alu_result,
    input  logic            zero_flag,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_zero,
    output logic            resp_err,
    input  logic            resp_ready
`ifdef RTYPE_SEQ_PERF_EN
    ,
    output logic [31:0]     retired_cnt,
    output logic [31:0]     illegal_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;
    state_t      state;
    logic [31:0] instr_q;
    logic        illegal_q;
    logic [3:0]  ctrl_d;
    logic        legal_d;
    always_comb begin
        ctrl_d  = 4'd0;
        legal_d = instr_q[6:0] == 7'b0110011;
        case ({instr_q[31:25], instr_q[14:12]})
            {7'b0000000, 3'b000}: ctrl_d = 4'd0;
            {7'b0100000, 3'b000}: ctrl_d = 4'd1;
            {7'b0000000, 3'b001}: ctrl_d = 4'd2;
            {7'b0000000, 3'b010}: ctrl_d = 4'd3;
            {7'b0000000, 3'b011}: ctrl_d = 4'd4;
            {7'b0000000, 3'b100}: ctrl_d = 4'd5;
            {7'b0000000, 3'b101}: ctrl_d = 4'd6;
            {7'b0100000, 3'b101}: ctrl_d = 4'd7;
            {7'b0000000, 3'b110}: ctrl_d = 4'd8;
            {7'b0000000, 3'b111}: ctrl_d = 4'd9;
            default:              legal_d = 1'b0;
        endcase
        ctrl_d = legal_d ? ctrl_d : 4'd0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            instr_q     <= '0;
            illegal_q   <= 1'b0;
            instr_ready <= 1'b1;
            rs1_addr    <= '0;
            rs2_addr    <= '0;
            rd_addr     <= '0;
            alu_ctrl    <= '0;
            reg_write   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
`ifdef RTYPE_SEQ_PERF_EN
            retired_cnt <= '0;
            illegal_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (instr_valid) begin
                    instr_q     <= instr;
                    instr_ready <= 1'b0;
                    state       <= DECODE;
                end
                DECODE: begin
                    rs1_addr  <= instr_q[19:15];
                    rs2_addr  <= instr_q[24:20];
                    rd_addr   <= instr_q[11:7];
                    alu_ctrl  <= ctrl_d;
                    illegal_q <= !legal_d;
                    // strobe is registered here so it is high for exactly the EXEC cycle
                    reg_write <= legal_d && instr_q[11:7] != 5'd0;
                    state     <= EXEC;
                end
                EXEC: begin
                    reg_write  <= 1'b0;
                    resp_data  <= alu_result;
                    resp_zero  <= zero_flag;
                    resp_err   <= illegal_q;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_valid  <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
`ifdef RTYPE_SEQ_PERF_EN
                    retired_cnt <= retired_cnt + {31'd0, !resp_err};
                    illegal_cnt <= illegal_cnt + {31'd0, resp_err};
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rtype_sequencer.md
# rtype_sequencer

Multi-cycle controller that sequences the RV32I register-file/ALU datapath for R-type instructions. It accepts one 32-bit instruction word at a time over a valid/ready handshake and decodes opcode, funct3 and funct7. It then drives the datapath's register addresses, `alu_ctrl` and a single-cycle `reg_write`, and returns the ALU result and zero flag over a response handshake. It sits between the instruction source (bench or fetch unit) and `datapath`.

## Interface
- `XLEN`, default 32: width of datapath result and response data.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `instr_valid` input 1: instruction word present.
- `instr` input 32: RV32I instruction word.
- `instr_ready` output 1: sequencer accepts an instruction this cycle.
- `rs1_addr` output 5: to datapath.
- `rs2_addr` output 5: to datapath.
- `rd_addr` output 5: to datapath.
- `alu_ctrl` output 4: to datapath.
- `reg_write` output 1: to datapath, write strobe.
- `alu_result` input XLEN: from datapath.
- `zero_flag` input 1: from datapath.
- `resp_valid` output 1: response held.
- `resp_data` output XLEN: captured ALU result.
- `resp_zero` output 1: captured zero flag.
- `resp_err` output 1: instruction was illegal or unsupported; no write was performed.
- `resp_ready` input 1: consumer accepts the response.

## Operation
- FSM states: IDLE, DECODE, EXEC, RESP. Reset state is IDLE.
- **IDLE:** `instr_ready`=1. On `instr_valid & instr_ready`, latch `instr` and go to DECODE.
- **DECODE:**
  - Register `rs1_addr`=instr[19:15], `rs2_addr`=instr[24:20], `rd_addr`=instr[11:7] and the `alu_ctrl` encoding.
  - Compute the illegal flag. Go to EXEC.
- **EXEC:**
  - `reg_write`=1 only if the instruction is legal and rd≠0.
  - Capture `alu_result`, `zero_flag` and the illegal flag into the `resp_*` registers. Go to RESP.
- **RESP:** `resp_valid`=1. On `resp_ready`, go to IDLE.
- Legal means opcode 0110011 and a valid funct7/funct3 pair.
- `alu_ctrl` encoding by (funct7,funct3):
  - ADD (0000000,000) = 0000; SUB (0100000,000) = 0001
  - SLL (0000000,001) = 0010; SLT (0000000,010) = 0011
  - SLTU (0000000,011) = 0100; XOR (0000000,100) = 0101
  - SRL (0000000,101) = 0110; SRA (0100000,101) = 0111
  - OR (0000000,110) = 1000; AND (0000000,111) = 1001
- Any other combination is illegal: `alu_ctrl`=0000, no write, `resp_err`=1.
- rd=x0 with a legal instruction: no write, `resp_err`=0, result still reported.
- Address and `alu_ctrl` outputs are registered. They update only in DECODE and hold their value otherwise.

## Timing
- Reset values:
  - `instr_ready`=1 (in IDLE)
  - `reg_write`=0, `resp_valid`=0, `resp_err`=0, `resp_zero`=0
  - `resp_data`=0, all addresses=0, `alu_ctrl`=0
- Latency: handshake accepted at edge N.
  - DECODE during cycle N+1.
  - EXEC during cycle N+2: `reg_write` is high for exactly this cycle, and the register-file write occurs at the end-of-cycle edge.
  - `resp_valid` rises in cycle N+3.
- Throughput: at most one instruction per 4 cycles. `instr_ready` is low in DECODE, EXEC and RESP.
- No combinational path from `resp_ready` back to `instr_ready`. IDLE is re-entered one cycle after the response handshake.
- Backpressure: while in RESP with `resp_ready`=0, `resp_*` stay stable and no further `reg_write` is issued.
- Reset mid-operation (any state):
  - Immediate return to IDLE; `reg_write` deasserts asynchronously.
  - The pending instruction and response are discarded.
- `instr_valid` is ignored outside IDLE.

## Configuration
- `RTYPE_SEQ_PERF_EN` defined: adds 32-bit output `retired_cnt` and 32-bit output `illegal_cnt`.
  - `retired_cnt` counts completed response handshakes with `resp_err`=0.
  - `illegal_cnt` counts completed response handshakes with `resp_err`=1.
  - Both reset to 0 and wrap at 2^32.
- Not defined: the counter ports and logic are absent; behaviour is otherwise identical.

## Test plan
- ADD x3,x1,x2 (0x002081B3), accepted at edge N -> at N+2: `rs1_addr`=1, `rs2_addr`=2, `rd_addr`=3, `alu_ctrl`=0000, `reg_write`=1 for one cycle. At N+3: `resp_valid`=1, `resp_err`=0.
- SUB x5,x6,x7 (0x407302B3) with rs1=rs2 value -> `alu_ctrl`=0001, `resp_data`=0, `resp_zero`=1.
- ADDI word 0x00000013 -> `reg_write` never asserts, `resp_err`=1, `alu_ctrl`=0000. With `RTYPE_SEQ_PERF_EN`: `illegal_cnt` increments to 1.
- ADD x0,x1,x2 (0x00208033) -> `reg_write` stays 0, `resp_err`=0, `resp_valid` at N+3.
- Hold `resp_ready`=0 for 5 cycles after `resp_valid` -> `resp_*` stable, `instr_ready`=0, single `reg_write` pulse total. One cycle after the handshake, `instr_ready`=1.
- Assert `rst` during EXEC -> `reg_write` drops immediately, FSM in IDLE, `resp_valid`=0, all outputs at reset values.
